// File: rtl/fwdcombine_rr_pkg.sv
// Shared forwarder definitions: packet-length width derivation used by
// the combiner, the two-way forwarder mux and the snoop splitter.
package fwdcombine_rr_pkg;

    localparam int FWD_ADDR_WIDTH = 9;
    localparam int FWD_DATA_WIDTH = 64;

    // A packet may fill the whole packetmem, so one extra bit is needed.
    function automatic int plen_width(input int addr_width);
        return addr_width + 1;
    endfunction

endpackage

// File: rtl/fwd_sel_delay.sv
// Select-pointer delay line matching the packetmem read latency;
// a plain wire when the latency is zero.
module fwd_sel_delay
    import fwdcombine_rr_pkg::*;
#(
    parameter int SEL_WIDTH  = 2,
    parameter int RD_LATENCY = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [SEL_WIDTH-1:0] sel,
    output logic [SEL_WIDTH-1:0] sel_late
);

    generate
        if (RD_LATENCY == 0) begin : g_pass
            logic unused_clk_rst;
            assign unused_clk_rst = clk ^ rst;
            assign sel_late = sel;
        end else begin : g_shift
            logic [SEL_WIDTH-1:0] stage [RD_LATENCY];

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int i = 0; i < RD_LATENCY; i++) begin
                        stage[i] <= '0;
                    end
                end else begin
                    stage[0] <= sel;
                    for (int i = 1; i < RD_LATENCY; i++) begin
                        stage[i] <= stage[i-1];
                    end
                end
            end

            assign sel_late = stage[RD_LATENCY-1];
        end
    endgenerate

endmodule

// File: rtl/fwdcombine_rr.sv
// N-way in-order forwarding combiner with its own round-robin pointer,
// advanced by each accepted forwarder_done.
module fwdcombine_rr
    import fwdcombine_rr_pkg::*;
#(
    parameter int N_CHAN     = 4,
    parameter int DATA_WIDTH = FWD_DATA_WIDTH,
    parameter int ADDR_WIDTH = FWD_ADDR_WIDTH,
    parameter int PLEN_WIDTH = plen_width(ADDR_WIDTH),
    parameter int RD_LATENCY = 1,
    parameter int SEL_WIDTH  = $clog2(N_CHAN)
) (
    input  logic                         clk,
    input  logic                         rst,
    output logic [ADDR_WIDTH-1:0]        forwarder_rd_addr_up,
    input  logic [N_CHAN*DATA_WIDTH-1:0] forwarder_rd_data_up,
    output logic [N_CHAN-1:0]            forwarder_rd_en_up,
    output logic [N_CHAN-1:0]            forwarder_done_up,
    input  logic [N_CHAN-1:0]            ready_for_forwarder_up,
    input  logic [N_CHAN*PLEN_WIDTH-1:0] len_to_forwarder_up,
    input  logic [ADDR_WIDTH-1:0]        forwarder_rd_addr,
    output logic [DATA_WIDTH-1:0]        forwarder_rd_data,
    input  logic                         forwarder_rd_en,
    input  logic                         forwarder_done,
    output logic                         ready_for_forwarder,
    output logic [PLEN_WIDTH-1:0]        len_to_forwarder,
    output logic [SEL_WIDTH-1:0]         cur_sel,
    output logic                         proto_err
);

    logic [SEL_WIDTH-1:0] sel;
    logic [SEL_WIDTH-1:0] sel_late;
    logic [N_CHAN-1:0]    hit;
    logic [N_CHAN-1:0]    hit_late;
    logic                 ready_sel;
    logic                 accept;

    generate
        for (genvar i = 0; i < N_CHAN; i++) begin : g_ch
            assign hit[i]      = (sel == SEL_WIDTH'(i));
            assign hit_late[i] = (sel_late == SEL_WIDTH'(i));
            assign forwarder_rd_en_up[i] = hit[i] & forwarder_rd_en & ~rst;
            assign forwarder_done_up[i]  = hit[i] & accept;
        end
    endgenerate

    always_comb begin
        len_to_forwarder  = '0;
        forwarder_rd_data = '0;
        for (int i = 0; i < N_CHAN; i++) begin
            if (hit[i]) begin
                len_to_forwarder = len_to_forwarder_up[i*PLEN_WIDTH +: PLEN_WIDTH];
            end
            if (hit_late[i]) begin
                forwarder_rd_data = forwarder_rd_data_up[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign ready_sel = |(ready_for_forwarder_up & hit);
    assign accept    = forwarder_done & ready_sel & ~rst;

    // Drop ready in the accepting cycle so the finished channel is not re-seen.
    assign ready_for_forwarder  = ready_sel & ~accept & ~rst;
    assign forwarder_rd_addr_up = forwarder_rd_addr;
    assign cur_sel              = sel;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sel       <= '0;
            proto_err <= 1'b0;
        end else begin
            if (accept) begin
                sel <= (sel == SEL_WIDTH'(N_CHAN - 1)) ? '0 : sel + SEL_WIDTH'(1);
            end
            if (forwarder_done & ~ready_sel) begin
                proto_err <= 1'b1;
            end
        end
    end

    fwd_sel_delay #(
        .SEL_WIDTH  (SEL_WIDTH),
        .RD_LATENCY (RD_LATENCY)
    ) u_sel_delay (
        .clk      (clk),
        .rst      (rst),
        .sel      (sel),
        .sel_late (sel_late)
    );

endmodule

// File: tb/tb_fwdcombine_rr.sv
// Bench for fwdcombine_rr: a 5-channel latency-2 instance and a
// 3-channel latency-0 instance against hand-derived vectors.
module tb_fwdcombine_rr;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    function automatic logic [63:0] mk(input int c, input logic [8:0] a);
        return {16'hC000 + 16'(c), 39'd0, a};
    endfunction

    function automatic logic [9:0] lenv(input int c);
        return (c == 2) ? 10'h1F0 : 10'(16 * c + 3);
    endfunction

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // ---- instance A: N_CHAN=5, RD_LATENCY=2
    logic [8:0]   a_addr_up;
    logic [319:0] a_data_up;
    logic [4:0]   a_en_up, a_dup, a_rdy;
    logic [49:0]  a_len_up;
    logic [8:0]   a_addr = '0;
    logic [63:0]  a_data;
    logic         a_rd = 1'b0, a_done = 1'b0, a_ready, a_perr;
    logic [9:0]   a_len;
    logic [2:0]   a_sel;
    logic [8:0]   a_p1, a_p2;

    always @(posedge clk) begin
        a_p1 <= a_addr_up;
        a_p2 <= a_p1;
    end

    always_comb begin
        a_data_up = '0;
        a_len_up  = '0;
        for (int c = 0; c < 5; c++) begin
            a_data_up[c*64 +: 64] = mk(c, a_p2);
            a_len_up[c*10 +: 10]  = lenv(c);
        end
    end

    fwdcombine_rr #(
        .N_CHAN(5), .DATA_WIDTH(64), .ADDR_WIDTH(9), .RD_LATENCY(2)
    ) dut_a (
        .clk                    (clk),
        .rst                    (rst),
        .forwarder_rd_addr_up   (a_addr_up),
        .forwarder_rd_data_up   (a_data_up),
        .forwarder_rd_en_up     (a_en_up),
        .forwarder_done_up      (a_dup),
        .ready_for_forwarder_up (a_rdy),
        .len_to_forwarder_up    (a_len_up),
        .forwarder_rd_addr      (a_addr),
        .forwarder_rd_data      (a_data),
        .forwarder_rd_en        (a_rd),
        .forwarder_done         (a_done),
        .ready_for_forwarder    (a_ready),
        .len_to_forwarder       (a_len),
        .cur_sel                (a_sel),
        .proto_err              (a_perr)
    );

    // ---- instance B: N_CHAN=3, RD_LATENCY=0
    logic [8:0]   b_addr_up;
    logic [191:0] b_data_up;
    logic [2:0]   b_en_up, b_dup;
    logic [2:0]   b_rdy = 3'b111;
    logic [29:0]  b_len_up;
    logic [8:0]   b_addr = '0;
    logic [63:0]  b_data;
    logic         b_rd = 1'b0, b_done = 1'b0, b_ready, b_perr;
    logic [9:0]   b_len;
    logic [1:0]   b_sel;

    always_comb begin
        b_data_up = '0;
        b_len_up  = '0;
        for (int c = 0; c < 3; c++) begin
            b_data_up[c*64 +: 64] = mk(c, b_addr_up);
            b_len_up[c*10 +: 10]  = lenv(c);
        end
    end

    fwdcombine_rr #(
        .N_CHAN(3), .DATA_WIDTH(64), .ADDR_WIDTH(9), .RD_LATENCY(0)
    ) dut_b (
        .clk                    (clk),
        .rst                    (rst),
        .forwarder_rd_addr_up   (b_addr_up),
        .forwarder_rd_data_up   (b_data_up),
        .forwarder_rd_en_up     (b_en_up),
        .forwarder_done_up      (b_dup),
        .ready_for_forwarder_up (b_rdy),
        .len_to_forwarder_up    (b_len_up),
        .forwarder_rd_addr      (b_addr),
        .forwarder_rd_data      (b_data),
        .forwarder_rd_en        (b_rd),
        .forwarder_done         (b_done),
        .ready_for_forwarder    (b_ready),
        .len_to_forwarder       (b_len),
        .cur_sel                (b_sel),
        .proto_err              (b_perr)
    );

    // ---- read-data scoreboard for instance A
    typedef struct {
        int          due;
        logic [63:0] data;
    } sb_t;
    sb_t sbq[$];

    task automatic sb_check();
        sb_t e;
        if (sbq.size() > 0 && sbq[0].due == cyc) begin
            e = sbq.pop_front();
            chk("rd_data_a", a_data, e.data);
        end
    endtask

    typedef struct {
        logic       done;
        logic       rd;
        logic [4:0] rdy;
        logic [8:0] addr;
        int         sel;
        logic [4:0] dup;
        logic [4:0] enu;
        logic       ready;
        logic       perr;
    } vec_t;
    vec_t tbl[12];

    initial begin
        tbl[0]  = '{1'b0, 1'b0, 5'h1F, 9'd0, 0, 5'h00, 5'h00, 1'b1, 1'b0};
        tbl[1]  = '{1'b1, 1'b1, 5'h1F, 9'd5, 0, 5'h01, 5'h01, 1'b0, 1'b0};
        tbl[2]  = '{1'b0, 1'b0, 5'h1F, 9'd0, 1, 5'h00, 5'h00, 1'b1, 1'b0};
        tbl[3]  = '{1'b0, 1'b0, 5'h1F, 9'd0, 1, 5'h00, 5'h00, 1'b1, 1'b0};
        tbl[4]  = '{1'b1, 1'b1, 5'h1F, 9'd7, 1, 5'h02, 5'h02, 1'b0, 1'b0};
        tbl[5]  = '{1'b1, 1'b0, 5'h1F, 9'd0, 2, 5'h04, 5'h00, 1'b0, 1'b0};
        tbl[6]  = '{1'b1, 1'b0, 5'h17, 9'd0, 3, 5'h00, 5'h00, 1'b0, 1'b0};
        tbl[7]  = '{1'b0, 1'b0, 5'h1F, 9'd0, 3, 5'h00, 5'h00, 1'b1, 1'b1};
        tbl[8]  = '{1'b1, 1'b0, 5'h1F, 9'd0, 3, 5'h08, 5'h00, 1'b0, 1'b1};
        tbl[9]  = '{1'b1, 1'b1, 5'h1F, 9'd3, 4, 5'h10, 5'h10, 1'b0, 1'b1};
        tbl[10] = '{1'b0, 1'b0, 5'h1F, 9'd0, 0, 5'h00, 5'h00, 1'b1, 1'b1};
        tbl[11] = '{1'b0, 1'b1, 5'h1E, 9'd9, 0, 5'h00, 5'h01, 1'b0, 1'b1};

        a_rdy = 5'h1F;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        for (int r = 0; r < 12; r++) begin
            @(negedge clk);
            a_done = tbl[r].done;
            a_rd   = tbl[r].rd;
            a_rdy  = tbl[r].rdy;
            a_addr = tbl[r].addr;
            #1;
            chk($sformatf("sel_a[%0d]", r), 64'(a_sel), 64'(tbl[r].sel));
            chk($sformatf("done_up_a[%0d]", r), 64'(a_dup), 64'(tbl[r].dup));
            chk($sformatf("rd_en_up_a[%0d]", r), 64'(a_en_up), 64'(tbl[r].enu));
            chk($sformatf("ready_a[%0d]", r), 64'(a_ready), 64'(tbl[r].ready));
            chk($sformatf("perr_a[%0d]", r), 64'(a_perr), 64'(tbl[r].perr));
            chk($sformatf("len_a[%0d]", r), 64'(a_len), 64'(lenv(tbl[r].sel)));
            chk($sformatf("addr_up_a[%0d]", r), 64'(a_addr_up), 64'(tbl[r].addr));
            sb_check();
            if (tbl[r].rd) sbq.push_back('{cyc + 2, mk(tbl[r].sel, tbl[r].addr)});
        end

        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            a_done = 1'b0;
            a_rd   = 1'b0;
            a_rdy  = 5'h1F;
            #1;
            sb_check();
        end
        chk("sb_drained", 64'(sbq.size()), 64'd0);

        // bring A to sel=2, then reset asynchronously mid-packet
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            a_done = 1'b1;
        end
        @(negedge clk);
        a_done = 1'b0;
        a_rd   = 1'b1;
        #1;
        chk("sel_before_rst", 64'(a_sel), 64'd2);
        chk("rd_en_before_rst", 64'(a_en_up), 64'h04);
        a_done = 1'b1;
        #1;
        rst = 1'b1;
        #1;
        chk("sel_async_rst", 64'(a_sel), 64'd0);
        chk("rd_en_async_rst", 64'(a_en_up), 64'd0);
        chk("done_async_rst", 64'(a_dup), 64'd0);
        chk("ready_async_rst", 64'(a_ready), 64'd0);
        chk("perr_async_rst", 64'(a_perr), 64'd0);
        @(posedge clk);
        #1;
        chk("sel_in_rst", 64'(a_sel), 64'd0);
        chk("done_in_rst", 64'(a_dup), 64'd0);
        @(negedge clk);
        rst    = 1'b0;
        a_done = 1'b0;
        a_rd   = 1'b0;
        sbq.delete();
        #1;
        chk("ready_after_rst", 64'(a_ready), 64'd1);
        @(negedge clk);
        a_done = 1'b1;
        #1;
        chk("done_after_rst", 64'(a_dup), 64'h01);
        @(negedge clk);
        a_done = 1'b0;
        #1;
        chk("sel_after_rst", 64'(a_sel), 64'd1);
        chk("perr_after_rst", 64'(a_perr), 64'd0);

        // instance B: back-to-back dones, combinational read data
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            b_done = 1'b1;
            b_rd   = 1'b1;
            b_addr = 9'(20 + k);
            #1;
            chk($sformatf("sel_b[%0d]", k), 64'(b_sel), 64'(k % 3));
            chk($sformatf("done_up_b[%0d]", k), 64'(b_dup), 64'(1 << (k % 3)));
            chk($sformatf("rd_en_up_b[%0d]", k), 64'(b_en_up), 64'(1 << (k % 3)));
            chk($sformatf("rd_data_b[%0d]", k), b_data, mk(k % 3, 9'(20 + k)));
            chk($sformatf("ready_b[%0d]", k), 64'(b_ready), 64'd0);
        end
        @(negedge clk);
        b_done = 1'b0;
        b_rd   = 1'b0;
        #1;
        chk("sel_b_end", 64'(b_sel), 64'd1);
        chk("perr_b_end", 64'(b_perr), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fwdcombine_rr.md
Name: fwdcombine_rr

Overview:
N-way, in-order forwarding combiner, the parametrised successor of the two-way forwarder mux. It sits between N VM/packetmem outputs (or N split stages) and one forwarder, and owns its own round-robin select pointer instead of taking an external sel. The pointer advances on each forwarder_done, which guarantees packets leave in the order the matching snoopsplit distributed them. Read data is steered with a select delayed by the packetmem read latency, so data in flight across a pointer change still comes from the correct channel.

Parameters:
N_CHAN, 4, number of upstream channels (>=2; need not be a power of two)
DATA_WIDTH, 64, packetmem read data width
ADDR_WIDTH, 9, packetmem read address width
PLEN_WIDTH, ADDR_WIDTH+1, packet length width
RD_LATENCY, 1, packetmem read latency in cycles (0..4)
SEL_WIDTH, $clog2(N_CHAN), select pointer width (derived; not overridden)

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
forwarder_rd_addr_up  out  ADDR_WIDTH  read address broadcast to all channels
forwarder_rd_data_up  in  N_CHAN*DATA_WIDTH  per-channel read data; channel i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
forwarder_rd_en_up  out  N_CHAN  per-channel read enable
forwarder_done_up  out  N_CHAN  per-channel 1-cycle done pulse
ready_for_forwarder_up  in  N_CHAN  per-channel packet-ready flag
len_to_forwarder_up  in  N_CHAN*PLEN_WIDTH  per-channel packet length
forwarder_rd_addr  in  ADDR_WIDTH  read address from the downstream forwarder
forwarder_rd_data  out  DATA_WIDTH  steered read data
forwarder_rd_en  in  1  downstream read enable
forwarder_done  in  1  downstream done; must be a 1-cycle pulse
ready_for_forwarder  out  1  ready flag of the selected channel
len_to_forwarder  out  PLEN_WIDTH  length of the selected channel
cur_sel  out  SEL_WIDTH  current select pointer (debug)
proto_err  out  1  sticky protocol-error flag

Behaviour:
- sel register:
  - Reset value 0.
  - On an accepted done (forwarder_done & ready_for_forwarder_up[sel]), sel becomes (sel==N_CHAN-1) ? 0 : sel+1 at the next edge.
  - cur_sel = sel.
- Accepted done: forwarder_done_up[sel] = 1 combinationally in the same cycle; every other bit is 0.
- Rejected done (forwarder_done while ready_for_forwarder_up[sel]=0):
  - Not forwarded to any channel.
  - sel holds.
  - proto_err sets at the next edge.
- proto_err: reset value 0; it is cleared only by rst.
- Read enable: forwarder_rd_en_up[sel] = forwarder_rd_en; every other bit is 0. Address is broadcast unmodified.
- ready_for_forwarder and len_to_forwarder:
  - Combinational mux on sel.
  - ready_for_forwarder is forced to 0 during the cycle in which an accepted done occurs, so the forwarder never sees the stale channel as ready again.
- Read-data steering:
  - sel_d is a shift register of depth RD_LATENCY, loaded with sel every cycle; reset value all 0.
  - forwarder_rd_data = channel[sel_d[RD_LATENCY-1]].
  - With RD_LATENCY=0, forwarder_rd_data = channel[sel] combinationally.
- Done and rd_en in the same cycle: the read goes to the old sel. Its data returns RD_LATENCY cycles later from the old channel, even though sel has already advanced.
- While rst is high:
  - All _up enables and dones are forced to 0.
  - ready_for_forwarder is forced to 0.
  - forwarder_rd_data, len_to_forwarder and forwarder_rd_addr_up stay muxed on sel (=0) and carry no reset-dependent value.
- Reset mid-packet: the pointer returns to 0 and in-flight read data is steered from channel 0. The upstream and downstream blocks are reset together, so no recovery is attempted.
- No latency on the control path (rd_en, done, ready, len): all combinational from sel. Only sel, sel_d and proto_err are state.

Decomposition:
- Shared forwarder header holds the PLEN_WIDTH derivation (ADDR_WIDTH+1) used by this block, fwdcombine and snoopsplit; it replaces the per-file define.
- One sub-module, fwd_sel_delay: a parametrised SEL_WIDTH x RD_LATENCY shift register with asynchronous reset and a pass-through when RD_LATENCY=0.
- Channel muxes are generate loops inside fwdcombine_rr.

Test Plan:
1. N_CHAN=3, all ready=1; issue 4 done pulses -> cur_sel steps 0,1,2,0; forwarder_done_up pulses 001,010,100,001; proto_err stays 0.
2. RD_LATENCY=2, sel=0; rd_en with addr 5 in the same cycle as done; channel 0 returns 0xAAAA two cycles later and channel 1 holds 0xBBBB -> forwarder_rd_data=0xAAAA in that cycle; forwarder_rd_en_up=01 at issue.
3. sel=1, ready_up=1101 (ch1 low); pulse done -> no forwarder_done_up bit set; cur_sel stays 1; proto_err=1 next cycle and remains 1 until rst.
4. sel=2, len_up ch2=0x1F0; ready_up[2]=1 -> len_to_forwarder=0x1F0 and ready_for_forwarder=1; in the done cycle ready_for_forwarder=0.
5. Assert rst asynchronously mid-packet (sel=2, rd_en=1) -> cur_sel=0, forwarder_rd_en_up=0 and forwarder_done_up=0 immediately without a clock edge; after release, behaves as from reset.
6. N_CHAN=5, RD_LATENCY=0; back-to-back done on every cycle for 10 cycles -> cur_sel wraps 4->0 twice; read data is combinationally channel[cur_sel].
